snake_collision_ctrl: RTL and testbench
=======================================

# snake_collision_ctrl

Game-control and collision block for the snake game. It watches the per-pixel overlap flags from the snake and apple renderers during each frame scan and latches any hit. On each frame `update` tick it resolves the latched hits into the `collision` code and the `game_state` code. These two codes feed the snake renderer, which moves, grows and resets the snake. The block owns the IDLE/PLAY/GAME_OVER state machine, the apple score and the apple-respawn request.

## Interface
Parameters:
- `BIT`, 10: width of pixel coordinates.
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `BORDER`, 10: wall thickness in pixels; the wall is drawn on all four edges.
- `OVER_FRAMES`, 120: number of `update` ticks spent in GAME_OVER before returning to IDLE (1..255).
- `HOLD`, 2: number of cycles `collision` holds APPLE_COLLECTED (1..15).

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `x_pos`, in, `BIT`: current scan column.
- `y_pos`, in, `BIT`: current scan line.
- `snake_head_active`, in, 1: head covers the current pixel.
- `snake_body_active`, in, 1: a body element covers the current pixel.
- `apple_active`, in, 1: apple covers the current pixel.
- `update`, in, 1: one-cycle frame tick; the snake moves on this same cycle.
- `start`, in, 1: start button, already synchronised and debounced (level).
- `collision`, out, 2: 00 = none, 01 = fatal (wall or self), 10 = apple collected. 11 is never driven.
- `game_state`, out, 2: 00 = IDLE, 01 = PLAY, 11 = GAME_OVER. 10 is never driven.
- `apple_respawn`, out, 1: one-cycle pulse requesting a new apple position.
- `score`, out, 8: number of apples eaten in the current game.

## Operation
- Pixel qualification: a pixel counts only when `x_pos < H_ACTIVE` and `y_pos < V_ACTIVE`.
- Wall pixel: a qualified pixel with `x_pos < BORDER`, `x_pos >= H_ACTIVE-BORDER`, `y_pos < BORDER` or `y_pos >= V_ACTIVE-BORDER`.
- Sticky frame latches:
  - `hit_apple` sets on head & apple.
  - `hit_self` sets on head & body.
  - `hit_wall` sets on head & wall pixel.
- Latch handling:
  - Latches set only in PLAY.
  - All three clear on every `update` cycle, after being sampled.
  - All three clear on entry to PLAY.
  - If a hit pixel coincides with an `update` cycle, that pixel is dropped: clear has priority.
- Resolution, on an `update` cycle in PLAY:
  - If `hit_wall` or `hit_self`: fatal. `collision` <= 01 and `game_state` <= GAME_OVER. Fatal has priority over apple; no score change and no respawn.
  - Else if `hit_apple`: `collision` <= 10 for exactly `HOLD` cycles, then 00. `apple_respawn` pulses once, on the same edge that `collision` first becomes 10. `score` increments and saturates at 255.
  - Else: `collision` <= 00.
- Re-trigger: an apple hit resolved while a previous HOLD window is still running restarts the window at `HOLD` and counts again.
- State machine:
  - IDLE: on a rising edge of `start` (previous-cycle sample 0, current 1), go to PLAY; `score` <= 0 and all latches clear.
  - PLAY: go to GAME_OVER on fatal, as described above.
  - GAME_OVER: the frame counter loads 0 on entry and increments on each `update`. When `update` arrives with the counter at `OVER_FRAMES-1`, go to IDLE. `collision` <= 00 on that edge.
  - `start` is ignored in PLAY and GAME_OVER. A `start` held high across the GAME_OVER→IDLE transition does not restart the game; a new rising edge is required.
- `score` holds its value through GAME_OVER and IDLE; it clears only on entry to PLAY.
- `collision` stays 01 for all of GAME_OVER.

## Timing
- All outputs are registered.
- Reset values: `game_state` = 00, `collision` = 00, `apple_respawn` = 0, `score` = 0. Latches, HOLD counter, frame counter and the `start` edge register are all 0.
- Asynchronous assertion of `reset` forces the reset values immediately, including mid-frame, mid-HOLD and mid-GAME_OVER. Release is taken at the next `clk` edge.
- Latency:
  - A hit pixel at cycle t sets its latch at edge t+1.
  - An `update` at cycle u drives `collision`/`game_state` at edge u+1.
  - The renderer therefore acts on this result at the next `update`.
- IDLE→PLAY: `start` rising at cycle s gives `game_state` = 01 from edge s+1.
- Counter widths: HOLD counter 4 bits; frame counter 8 bits.

## Test plan
- Start: reset low then high; `start` 0→1 at cycle 10 → `game_state` = 01 after edge 11, `score` = 0, `collision` = 00.
- Apple: in PLAY, head & apple at (100,100) for one pixel, then `update` at cycle u:
  - `collision` = 10 on cycles u+1 and u+2, then 00.
  - `apple_respawn` high on u+1 only.
  - `score` = 1.
- Wall and priority: in PLAY, head at (5,200), plus head & apple in the same frame, then `update` → `collision` = 01, `game_state` = 11, `score` unchanged, no respawn pulse.
- Self-hit and return, with `OVER_FRAMES` = 3: head & body in a frame, then `update` → GAME_OVER. Exactly 3 further `update` pulses → `game_state` = 00 and `collision` = 00. `start` held high throughout → stays IDLE until it toggles 0→1.
- Boundaries and saturation:
  - Head at x = 630 → fatal; head at x = 629 → no hit.
  - Head & apple at x = 700 (off-screen) → ignored.
  - 256 apple frames → `score` = 255.
  - Hit pixel on the `update` cycle itself → not counted.
- Async reset in the middle of a HOLD window and in the middle of GAME_OVER → all outputs at reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/snake_collision_ctrl.sv
// snake_collision_ctrl
// Game-control and collision block for the snake game. Latches head overlaps
// seen during the frame scan, resolves them on the frame update tick into a
// collision code and the IDLE/PLAY/GAME_OVER state, and keeps the apple score.
module snake_collision_ctrl #(
    parameter int BIT         = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BORDER      = 10,
    parameter int OVER_FRAMES = 120,
    parameter int HOLD        = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    input  logic           snake_head_active,
    input  logic           snake_body_active,
    input  logic           apple_active,
    input  logic           update,
    input  logic           start,
    output logic [1:0]     collision,
    output logic [1:0]     game_state,
    output logic           apple_respawn,
    output logic [7:0]     score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b11
    } state_t;

    localparam logic [1:0] COL_NONE  = 2'b00;
    localparam logic [1:0] COL_FATAL = 2'b01;
    localparam logic [1:0] COL_APPLE = 2'b10;

    // Screen geometry expressed at coordinate width to keep compares width-exact
    localparam logic [BIT-1:0] X_END      = BIT'(H_ACTIVE);
    localparam logic [BIT-1:0] Y_END      = BIT'(V_ACTIVE);
    localparam logic [BIT-1:0] X_LO_WALL  = BIT'(BORDER);
    localparam logic [BIT-1:0] Y_LO_WALL  = BIT'(BORDER);
    localparam logic [BIT-1:0] X_HI_WALL  = BIT'(H_ACTIVE - BORDER);
    localparam logic [BIT-1:0] Y_HI_WALL  = BIT'(V_ACTIVE - BORDER);
    // The first apple cycle is the load edge itself, so the counter holds the
    // number of extra cycles still to show
    localparam logic [3:0]     HOLD_EXTRA = 4'(HOLD - 1);
    localparam logic [7:0]     OVER_LAST  = 8'(OVER_FRAMES - 1);

    state_t     state_q, state_d;
    logic [1:0] collision_q, collision_d;
    logic       respawn_q, respawn_d;
    logic [7:0] score_q, score_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       start_q, start_d;
    logic       hit_apple_q, hit_apple_d;
    logic       hit_self_q, hit_self_d;
    logic       hit_wall_q, hit_wall_d;

    logic       pix_valid;
    logic       wall_pix;
    logic       start_rise;

    // Pixel qualification and wall detection for the current scan position
    always_comb begin
        pix_valid = (x_pos < X_END) && (y_pos < Y_END);
        wall_pix  = pix_valid && ((x_pos < X_LO_WALL) || (x_pos >= X_HI_WALL) ||
                                  (y_pos < Y_LO_WALL) || (y_pos >= Y_HI_WALL));
        start_rise = start && !start_q;
    end

    // Next-state, latch, score and collision-code logic
    always_comb begin
        state_d     = state_q;
        collision_d = collision_q;
        respawn_d   = 1'b0;
        score_d     = score_q;
        hold_cnt_d  = hold_cnt_q;
        frame_cnt_d = frame_cnt_q;
        start_d     = start;
        hit_apple_d = hit_apple_q;
        hit_self_d  = hit_self_q;
        hit_wall_d  = hit_wall_q;

        // Apple display window runs down on its own; it ends by returning to none
        if (hold_cnt_q != 4'd0) begin
            hold_cnt_d = hold_cnt_q - 4'd1;
        end else if (collision_q == COL_APPLE) begin
            collision_d = COL_NONE;
        end

        // Sticky hit latches: only armed in PLAY, a hit on the update cycle is dropped
        if (state_q == ST_PLAY && !update) begin
            if (snake_head_active && apple_active && pix_valid) hit_apple_d = 1'b1;
            if (snake_head_active && snake_body_active && pix_valid) hit_self_d = 1'b1;
            if (snake_head_active && wall_pix) hit_wall_d = 1'b1;
        end
        if (update) begin
            hit_apple_d = 1'b0;
            hit_self_d  = 1'b0;
            hit_wall_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d     = ST_PLAY;
                    score_d     = 8'd0;
                    collision_d = COL_NONE;
                    hold_cnt_d  = 4'd0;
                    hit_apple_d = 1'b0;
                    hit_self_d  = 1'b0;
                    hit_wall_d  = 1'b0;
                end
            end
            ST_PLAY: begin
                if (update) begin
                    if (hit_wall_q || hit_self_q) begin
                        state_d     = ST_OVER;
                        collision_d = COL_FATAL;
                        hold_cnt_d  = 4'd0;
                        frame_cnt_d = 8'd0;
                    end else if (hit_apple_q) begin
                        collision_d = COL_APPLE;
                        hold_cnt_d  = HOLD_EXTRA;
                        respawn_d   = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end else begin
                        collision_d = COL_NONE;
                        hold_cnt_d  = 4'd0;
                    end
                end
            end
            ST_OVER: begin
                collision_d = COL_FATAL;
                if (update) begin
                    if (frame_cnt_q == OVER_LAST) begin
                        state_d     = ST_IDLE;
                        collision_d = COL_NONE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                collision_d = COL_NONE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            collision_q <= COL_NONE;
            respawn_q   <= 1'b0;
            score_q     <= 8'd0;
            hold_cnt_q  <= 4'd0;
            frame_cnt_q <= 8'd0;
            start_q     <= 1'b0;
            hit_apple_q <= 1'b0;
            hit_self_q  <= 1'b0;
            hit_wall_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            collision_q <= collision_d;
            respawn_q   <= respawn_d;
            score_q     <= score_d;
            hold_cnt_q  <= hold_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            start_q     <= start_d;
            hit_apple_q <= hit_apple_d;
            hit_self_q  <= hit_self_d;
            hit_wall_q  <= hit_wall_d;
        end
    end

    assign collision     = collision_q;
    assign game_state    = state_q;
    assign apple_respawn = respawn_q;
    assign score         = score_q;

endmodule

// File: tb/tb_snake_collision_ctrl.sv
// Testbench for snake_collision_ctrl: directed frame scenarios checked every
// cycle against an event-level game model, plus literal spot checks.
module tb_snake_collision_ctrl;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int B  = 10;
    localparam int OF = 3;
    localparam int HD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic       snake_head_active = 1'b0;
    logic       snake_body_active = 1'b0;
    logic       apple_active = 1'b0;
    logic       update = 1'b0;
    logic       start = 1'b0;
    logic [1:0] collision;
    logic [1:0] game_state;
    logic       apple_respawn;
    logic [7:0] score;

    int checks = 0;
    int failures = 0;

    snake_collision_ctrl #(
        .BIT(10), .H_ACTIVE(H), .V_ACTIVE(V), .BORDER(B),
        .OVER_FRAMES(OF), .HOLD(HD)
    ) dut (
        .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .snake_head_active(snake_head_active), .snake_body_active(snake_body_active),
        .apple_active(apple_active), .update(update), .start(start),
        .collision(collision), .game_state(game_state),
        .apple_respawn(apple_respawn), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- game model (event level) ----------------
    int  m_state;        // 0 idle, 1 play, 3 game over
    int  m_score;
    int  m_over_upd;     // updates seen since entering game over
    int  cyc_n;          // clock edges since start of sim
    int  apple_cyc;      // edge at which the last apple was resolved
    bit  apple_win;      // an apple resolution is the latest outcome in this game
    bit  m_prev_start, m_ha, m_hs, m_hw;
    bit  rise, qual, wallp;
    int  xi, yi;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_score = 0; m_over_upd = 0; apple_win = 0;
            m_prev_start = 0; m_ha = 0; m_hs = 0; m_hw = 0;
        end else begin
            cyc_n++;
            rise = start && !m_prev_start;
            m_prev_start = start;
            xi = int'(x_pos); yi = int'(y_pos);
            qual  = (xi < H) && (yi < V);
            wallp = qual && (xi < B || xi >= H - B || yi < B || yi >= V - B);
            if (m_state == 0) begin
                if (rise) begin
                    m_state = 1; m_score = 0; m_ha = 0; m_hs = 0; m_hw = 0;
                end
            end else if (m_state == 1) begin
                if (update) begin
                    if (m_hw || m_hs) begin
                        m_state = 3; m_over_upd = 0; apple_win = 0;
                    end else if (m_ha) begin
                        apple_win = 1; apple_cyc = cyc_n;
                        if (m_score < 255) m_score++;
                    end else begin
                        apple_win = 0;
                    end
                    m_ha = 0; m_hs = 0; m_hw = 0;
                end else begin
                    if (snake_head_active && apple_active && qual) m_ha = 1;
                    if (snake_head_active && snake_body_active && qual) m_hs = 1;
                    if (snake_head_active && wallp) m_hw = 1;
                end
            end else begin
                if (update) begin
                    m_over_upd++;
                    if (m_over_upd == OF) m_state = 0;
                end
            end
        end
    end

    // Compare DUT against the model shortly after every active edge
    always @(posedge clk) begin
        #1;
        chk("game_state", 32'(game_state), 32'(m_state));
        chk("collision", 32'(collision),
            (m_state == 3) ? 32'd1 : ((apple_win && (cyc_n - apple_cyc) < HD) ? 32'd2 : 32'd0));
        chk("apple_respawn", 32'(apple_respawn), (apple_win && cyc_n == apple_cyc) ? 32'd1 : 32'd0);
        chk("score", 32'(score), 32'(m_score));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int x, input int y, input bit h, input bit b, input bit a, input bit u);
        @(negedge clk);
        x_pos = 10'(x); y_pos = 10'(y);
        snake_head_active = h; snake_body_active = b; apple_active = a; update = u;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Update tick followed by one idle cycle, so the result is visible afterwards
    task automatic upd();
        cyc(0, 0, 0, 0, 0, 1);
        nop(1);
    endtask

    task automatic restart();
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        chk("restart_state", 32'(game_state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
    endtask

    task automatic return_to_idle();
        for (int i = 0; i < OF; i++) begin
            nop(2);
            upd();
            if (i < OF - 1) chk("over_hold_state", 32'(game_state), 32'd3);
        end
        chk("over_exit_state", 32'(game_state), 32'd0);
        chk("over_exit_col", 32'(collision), 32'd0);
    endtask

    task automatic async_reset_check(input string name);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk({name, "_state"}, 32'(game_state), 32'd0);
        chk({name, "_col"}, 32'(collision), 32'd0);
        chk({name, "_resp"}, 32'(apple_respawn), 32'd0);
        chk({name, "_score"}, 32'(score), 32'd0);
        start = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        nop(2);
        chk("reset_state", 32'(game_state), 32'd0);
        chk("reset_col", 32'(collision), 32'd0);
        chk("reset_score", 32'(score), 32'd0);
        @(negedge clk); reset = 1'b1;
        nop(8);

        // Start: rising edge moves to PLAY on the next edge
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        chk("start_state", 32'(game_state), 32'd1);
        chk("start_score", 32'(score), 32'd0);
        chk("start_col", 32'(collision), 32'd0);

        // Apple: two cycles of code 10, one respawn pulse, score 1
        cyc(100, 100, 1, 0, 1, 0);
        nop(2);
        upd();
        chk("apple_col1", 32'(collision), 32'd2);
        chk("apple_resp1", 32'(apple_respawn), 32'd1);
        chk("apple_score", 32'(score), 32'd1);
        nop(1);
        chk("apple_col2", 32'(collision), 32'd2);
        chk("apple_resp2", 32'(apple_respawn), 32'd0);
        nop(1);
        chk("apple_col3", 32'(collision), 32'd0);

        // Boundaries: x=629 safe, off-screen apple ignored, hit on update dropped
        cyc(629, 200, 1, 0, 0, 0);
        upd();
        chk("x629_state", 32'(game_state), 32'd1);
        cyc(700, 100, 1, 0, 1, 0);
        upd();
        chk("offscreen_score", 32'(score), 32'd1);
        cyc(100, 100, 1, 0, 1, 1);
        nop(1);
        chk("updhit_col", 32'(collision), 32'd0);
        upd();
        chk("updhit_score", 32'(score), 32'd1);

        // Wall and apple in one frame: fatal wins
        cyc(5, 200, 1, 0, 0, 0);
        cyc(100, 100, 1, 0, 1, 0);
        upd();
        chk("wall_col", 32'(collision), 32'd1);
        chk("wall_state", 32'(game_state), 32'd3);
        chk("wall_score", 32'(score), 32'd1);
        chk("wall_resp", 32'(apple_respawn), 32'd0);
        return_to_idle();
        nop(5);
        chk("held_start_idle", 32'(game_state), 32'd0);
        restart();

        // Right wall edge x=630 is fatal
        cyc(630, 200, 1, 0, 0, 0);
        upd();
        chk("x630_state", 32'(game_state), 32'd3);
        return_to_idle();
        restart();

        // Self hit
        cyc(300, 300, 1, 1, 0, 0);
        upd();
        chk("self_state", 32'(game_state), 32'd3);
        chk("self_col", 32'(collision), 32'd1);
        return_to_idle();
        nop(4);
        chk("self_idle_hold", 32'(game_state), 32'd0);
        restart();

        // Score saturation over 256 apple frames
        for (int i = 0; i < 256; i++) begin
            cyc(100, 100, 1, 0, 1, 0);
            upd();
            nop(2);
        end
        chk("sat_score", 32'(score), 32'd255);

        // Async reset inside an apple window
        cyc(200, 200, 1, 0, 1, 0);
        upd();
        chk("hold_before_rst", 32'(collision), 32'd2);
        async_reset_check("rst_hold");
        restart();

        // Async reset in GAME_OVER
        cyc(5, 200, 1, 0, 0, 0);
        upd();
        chk("over_before_rst", 32'(game_state), 32'd3);
        nop(2);
        upd();
        async_reset_check("rst_over");
        nop(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
